// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, ALU selects, FSM encoding and the control bundle for the
// multi-cycle control unit.
package cpu_ctrl_pkg;

    localparam logic [31:0] OP_LOADI = 32'h00;
    localparam logic [31:0] OP_MOV   = 32'h01;
    localparam logic [31:0] OP_ADD   = 32'h02;
    localparam logic [31:0] OP_SUB   = 32'h03;
    localparam logic [31:0] OP_AND   = 32'h04;
    localparam logic [31:0] OP_OR    = 32'h05;
    localparam logic [31:0] OP_JUMP  = 32'h06;
    localparam logic [31:0] OP_BEQ   = 32'h07;
    localparam logic [31:0] OP_LWD   = 32'h08;
    localparam logic [31:0] OP_LWI   = 32'h09;
    localparam logic [31:0] OP_SWD   = 32'h0A;
    localparam logic [31:0] OP_SWI   = 32'h0B;
    localparam logic [31:0] OP_MULT  = 32'h0C;
    localparam logic [31:0] OP_SLL   = 32'h0D;
    localparam logic [31:0] OP_SRL   = 32'h0E;
    localparam logic [31:0] OP_SRA   = 32'h0F;
    localparam logic [31:0] OP_ROR   = 32'h10;
    localparam logic [31:0] OP_BNE   = 32'h11;

    localparam logic [3:0] ALU_FWD = 4'h0;
    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_JMP = 4'h4;
    localparam logic [3:0] ALU_LD  = 4'h5;
    localparam logic [3:0] ALU_ST  = 4'h6;
    localparam logic [3:0] ALU_MUL = 4'h7;
    localparam logic [3:0] ALU_SLL = 4'h8;
    localparam logic [3:0] ALU_SRL = 4'h9;
    localparam logic [3:0] ALU_SRA = 4'hA;
    localparam logic [3:0] ALU_ROR = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_WB       = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] aluop;
        logic       we;
        logic       twos;
        logic       immed;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       wmux;
        logic       read;
        logic       write;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode -> control bundle; extended ops decode as illegal
// when EN_EXT is 0.
module ctrl_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int EN_EXT   = 1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                is_mem,
    output logic                is_load,
    output logic                illegal
);

    logic [31:0] opx;
    logic        ext;

    assign opx = 32'(opcode);
    assign ext = (EN_EXT != 0);

    always_comb begin
        ctrl = '0;
        case (opx)
            OP_LOADI: begin ctrl.aluop = ALU_FWD; ctrl.we = 1'b1; ctrl.immed = 1'b1; end
            OP_MOV:   begin ctrl.aluop = ALU_FWD; ctrl.we = 1'b1; end
            OP_ADD:   begin ctrl.aluop = ALU_ADD; ctrl.we = 1'b1; end
            OP_SUB:   begin ctrl.aluop = ALU_ADD; ctrl.we = 1'b1; ctrl.twos = 1'b1; end
            OP_AND:   begin ctrl.aluop = ALU_AND; ctrl.we = 1'b1; end
            OP_OR:    begin ctrl.aluop = ALU_OR;  ctrl.we = 1'b1; end
            OP_JUMP:  begin ctrl.aluop = ALU_JMP; ctrl.jump = 1'b1; end
            OP_BEQ:   begin ctrl.aluop = ALU_ADD; ctrl.twos = 1'b1; ctrl.branch = 1'b1; end
            // loads write back only from the WB state, so we stays low here
            OP_LWD:   begin ctrl.aluop = ALU_LD;  ctrl.read = 1'b1; end
            OP_LWI:   begin ctrl.aluop = ALU_LD;  ctrl.read = 1'b1; ctrl.immed = 1'b1; end
            OP_SWD:   begin ctrl.aluop = ALU_ST;  ctrl.write = 1'b1; end
            OP_SWI:   begin ctrl.aluop = ALU_ST;  ctrl.write = 1'b1; ctrl.immed = 1'b1; end
            OP_MULT:  if (ext) begin ctrl.aluop = ALU_MUL; ctrl.we = 1'b1; end
                      else ctrl.illegal = 1'b1;
            OP_SLL:   if (ext) begin ctrl.aluop = ALU_SLL; ctrl.we = 1'b1; ctrl.immed = 1'b1; end
                      else ctrl.illegal = 1'b1;
            OP_SRL:   if (ext) begin ctrl.aluop = ALU_SRL; ctrl.we = 1'b1; ctrl.immed = 1'b1; end
                      else ctrl.illegal = 1'b1;
            OP_SRA:   if (ext) begin ctrl.aluop = ALU_SRA; ctrl.we = 1'b1; ctrl.immed = 1'b1; end
                      else ctrl.illegal = 1'b1;
            OP_ROR:   if (ext) begin ctrl.aluop = ALU_ROR; ctrl.we = 1'b1; ctrl.immed = 1'b1; end
                      else ctrl.illegal = 1'b1;
            OP_BNE:   if (ext) begin ctrl.aluop = ALU_ADD; ctrl.twos = 1'b1; ctrl.bne = 1'b1; end
                      else ctrl.illegal = 1'b1;
            default:  ctrl.illegal = 1'b1;
        endcase
    end

    assign is_mem  = ctrl.read | ctrl.write;
    assign is_load = ctrl.read;
    assign illegal = ctrl.illegal;

endmodule

// File: rtl/mc_control_unit.sv
// Registered multi-cycle control unit: decode on accept, hold memory strobes
// through BUSYWAIT, write loads back in a dedicated WB cycle.
module mc_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int OPCODE_W = 8,
    parameter int ALUOP_W  = 4,
    parameter int EN_EXT   = 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    input  logic               INSTR_VALID,
    output logic               INSTR_READY,
    input  logic               BUSYWAIT,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic               WRITEENABLE,
    output logic               TWOSCOMPMUX_SEL,
    output logic               IMMEDMUX_SEL,
    output logic               BRANCHENABLE,
    output logic               BNEENABLE,
    output logic               JUMPENABLE,
    output logic               WRITEMUX_SEL,
    output logic               READ,
    output logic               WRITE,
    output logic               ILLEGAL
);

    state_t              state;
    ctrl_t               ctrl_q;
    ctrl_t               dec;
    logic                dec_mem, dec_load, dec_ill;
    logic                mem_q, load_q;
    logic                accept;
    logic [OPCODE_W-1:0] opcode;
    logic                unused_operand;

    assign opcode         = INSTRUCTION[INSTR_W-1 -: OPCODE_W];
    assign unused_operand = ^INSTRUCTION[INSTR_W-OPCODE_W-1:0];

    ctrl_decoder #(.OPCODE_W(OPCODE_W), .EN_EXT(EN_EXT)) u_dec (
        .opcode  (opcode),
        .ctrl    (dec),
        .is_mem  (dec_mem),
        .is_load (dec_load),
        .illegal (dec_ill)
    );

    // Stores free the issue slot in the cycle their access completes.
    always_comb begin
        case (state)
            S_IDLE:     INSTR_READY = 1'b1;
            S_EXEC:     INSTR_READY = !mem_q;
            S_MEM_WAIT: INSTR_READY = !load_q && !BUSYWAIT;
            default:    INSTR_READY = 1'b1;
        endcase
    end

    assign accept = INSTR_VALID && INSTR_READY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= S_IDLE;
            ctrl_q <= '0;
            mem_q  <= 1'b0;
            load_q <= 1'b0;
        end else if (accept) begin
            state          <= S_EXEC;
            ctrl_q         <= dec;
            ctrl_q.illegal <= dec_ill;
            mem_q          <= dec_mem;
            load_q         <= dec_load;
        end else begin
            case (state)
                S_EXEC: begin
                    if (mem_q) state <= S_MEM_WAIT;
                    else begin
                        state  <= S_IDLE;
                        ctrl_q <= '0;
                    end
                end
                S_MEM_WAIT: begin
                    if (!BUSYWAIT) begin
                        if (load_q) begin
                            state       <= S_WB;
                            ctrl_q.read <= 1'b0;
                            ctrl_q.we   <= 1'b1;
                            ctrl_q.wmux <= 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            ctrl_q <= '0;
                        end
                    end
                end
                S_WB: begin
                    state  <= S_IDLE;
                    ctrl_q <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ALUOP           = ALUOP_W'(ctrl_q.aluop);
    assign WRITEENABLE     = ctrl_q.we;
    assign TWOSCOMPMUX_SEL = ctrl_q.twos;
    assign IMMEDMUX_SEL    = ctrl_q.immed;
    assign BRANCHENABLE    = ctrl_q.branch;
    assign BNEENABLE       = ctrl_q.bne;
    assign JUMPENABLE      = ctrl_q.jump;
    assign WRITEMUX_SEL    = ctrl_q.wmux;
    assign READ            = ctrl_q.read;
    assign WRITE           = ctrl_q.write;
    assign ILLEGAL         = ctrl_q.illegal;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench: one unit with the extended op set, one without, fed the
// same instruction stream.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        valid;
    logic        busy;

    logic [3:0] aluop_e, aluop_b;
    logic ready_e, we_e, tc_e, imm_e, br_e, bne_e, j_e, wm_e, rd_e, wr_e, ill_e;
    logic ready_b, we_b, tc_b, imm_b, br_b, bne_b, j_b, wm_b, rd_b, wr_b, ill_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_control_unit #(.INSTR_W(32), .OPCODE_W(8), .ALUOP_W(4), .EN_EXT(1)) u_ext (
        .CLK(clk), .RESET_N(rst_n), .INSTRUCTION(instr), .INSTR_VALID(valid),
        .INSTR_READY(ready_e), .BUSYWAIT(busy), .ALUOP(aluop_e), .WRITEENABLE(we_e),
        .TWOSCOMPMUX_SEL(tc_e), .IMMEDMUX_SEL(imm_e), .BRANCHENABLE(br_e),
        .BNEENABLE(bne_e), .JUMPENABLE(j_e), .WRITEMUX_SEL(wm_e), .READ(rd_e),
        .WRITE(wr_e), .ILLEGAL(ill_e)
    );

    mc_control_unit #(.INSTR_W(32), .OPCODE_W(8), .ALUOP_W(4), .EN_EXT(0)) u_base (
        .CLK(clk), .RESET_N(rst_n), .INSTRUCTION(instr), .INSTR_VALID(valid),
        .INSTR_READY(ready_b), .BUSYWAIT(busy), .ALUOP(aluop_b), .WRITEENABLE(we_b),
        .TWOSCOMPMUX_SEL(tc_b), .IMMEDMUX_SEL(imm_b), .BRANCHENABLE(br_b),
        .BNEENABLE(bne_b), .JUMPENABLE(j_b), .WRITEMUX_SEL(wm_b), .READ(rd_b),
        .WRITE(wr_b), .ILLEGAL(ill_b)
    );

    // {ALUOP, WE, TC, IMM, BR, BNE, J, WM, RD, WR, ILL}
    logic [13:0] out_e, out_b;
    assign out_e = {aluop_e, we_e, tc_e, imm_e, br_e, bne_e, j_e, wm_e, rd_e, wr_e, ill_e};
    assign out_b = {aluop_b, we_b, tc_b, imm_b, br_b, bne_b, j_b, wm_b, rd_b, wr_b, ill_b};

    function automatic logic [13:0] ev(input logic [3:0] a, input logic [9:0] f);
        return {a, f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        instr = 32'h0;
        valid = 1'b0;
        busy  = 1'b0;
        cyc();
        cyc();
        chk("reset_outs", 32'(out_e), 32'(ev(4'h0, 10'b0000000000)));
        chk("reset_ready", 32'(ready_e), 32'd1);
        rst_n = 1'b1;
        cyc();

        // back-to-back add, sub
        instr = 32'h0200_0000; valid = 1'b1;
        cyc();
        chk("add_outs", 32'(out_e), 32'(ev(4'h1, 10'b1000000000)));
        chk("add_ready", 32'(ready_e), 32'd1);
        instr = 32'h0300_0000;
        cyc();
        chk("sub_outs", 32'(out_e), 32'(ev(4'h1, 10'b1100000000)));
        chk("sub_ready", 32'(ready_e), 32'd1);
        valid = 1'b0;
        cyc();
        chk("idle_after_sub", 32'(out_e), 32'(ev(4'h0, 10'b0000000000)));
        instr = 32'h0400_0000;
        cyc();
        chk("no_accept_hold", 32'(out_e), 32'(ev(4'h0, 10'b0000000000)));

        // lwi with busy high for EXEC, MW1, MW2
        instr = 32'h0900_0000; valid = 1'b1;
        cyc();
        chk("lwi_exec", 32'(out_e), 32'(ev(4'h5, 10'b0010000100)));
        chk("lwi_exec_ready", 32'(ready_e), 32'd0);
        valid = 1'b0; busy = 1'b1;
        cyc();
        chk("lwi_mw1", 32'(out_e), 32'(ev(4'h5, 10'b0010000100)));
        chk("lwi_mw1_ready", 32'(ready_e), 32'd0);
        cyc();
        chk("lwi_mw2", 32'(out_e), 32'(ev(4'h5, 10'b0010000100)));
        cyc();
        chk("lwi_mw3", 32'(out_e), 32'(ev(4'h5, 10'b0010000100)));
        busy = 1'b0;
        #1;
        chk("lwi_mw3_ready", 32'(ready_e), 32'd0);
        cyc();
        chk("lwi_wb_we", 32'(we_e), 32'd1);
        chk("lwi_wb_wmux", 32'(wm_e), 32'd1);
        chk("lwi_wb_read", 32'(rd_e), 32'd0);
        chk("lwi_wb_ready", 32'(ready_e), 32'd1);
        cyc();
        chk("lwi_idle", 32'(out_e), 32'(ev(4'h0, 10'b0000000000)));

        // swd with zero wait, or accepted in the MEM_WAIT cycle
        instr = 32'h0A00_0000; valid = 1'b1;
        cyc();
        chk("swd_exec", 32'(out_e), 32'(ev(4'h6, 10'b0000000010)));
        chk("swd_exec_ready", 32'(ready_e), 32'd0);
        instr = 32'h0500_0000;
        cyc();
        chk("swd_mw", 32'(out_e), 32'(ev(4'h6, 10'b0000000010)));
        chk("swd_mw_ready", 32'(ready_e), 32'd1);
        cyc();
        chk("or_after_swd", 32'(out_e), 32'(ev(4'h3, 10'b1000000000)));
        valid = 1'b0;
        cyc();
        chk("idle_after_or", 32'(out_e), 32'(ev(4'h0, 10'b0000000000)));

        // extended ops and gating
        instr = 32'h0F00_0000; valid = 1'b1;
        cyc();
        chk("sra_ext", 32'(out_e), 32'(ev(4'hA, 10'b1010000000)));
        chk("sra_base_ill", 32'(out_b), 32'(ev(4'h0, 10'b0000000001)));
        instr = 32'h1100_0000;
        cyc();
        chk("bne_ext", 32'(out_e), 32'(ev(4'h1, 10'b0100100000)));
        chk("bne_base_ill", 32'(out_b), 32'(ev(4'h0, 10'b0000000001)));
        valid = 1'b0;
        cyc();
        chk("ext_idle", 32'(out_e), 32'(ev(4'h0, 10'b0000000000)));
        chk("base_idle", 32'(out_b), 32'(ev(4'h0, 10'b0000000000)));

        // undefined opcode
        instr = 32'hFF00_0000; valid = 1'b1;
        cyc();
        chk("undef_exec", 32'(out_e), 32'(ev(4'h0, 10'b0000000001)));
        valid = 1'b0;
        cyc();
        chk("undef_idle", 32'(out_e), 32'(ev(4'h0, 10'b0000000000)));
        chk("undef_ready", 32'(ready_e), 32'd1);

        // async reset in the middle of a stalled lwd
        instr = 32'h0800_0000; valid = 1'b1;
        cyc();
        chk("lwd_exec", 32'(out_e), 32'(ev(4'h5, 10'b0000000100)));
        valid = 1'b0; busy = 1'b1;
        cyc();
        chk("lwd_mw", 32'(out_e), 32'(ev(4'h5, 10'b0000000100)));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_read_drop", 32'(rd_e), 32'd0);
        chk("rst_outs", 32'(out_e), 32'(ev(4'h0, 10'b0000000000)));
        #1 rst_n = 1'b1;
        cyc();
        chk("post_rst_ready", 32'(ready_e), 32'd1);
        chk("post_rst_outs", 32'(out_e), 32'(ev(4'h0, 10'b0000000000)));
        busy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Registered, multi-cycle successor to the CPU's combinational decoder.
- Decodes INSTRUCTION[31:24] into ALU/mux/branch/memory control, with an optional extended op set (mult, shifts, rotate, bne).
- Holds memory strobes for as long as the data memory/cache asserts BUSYWAIT.
- Stalls instruction issue through an INSTR_VALID/INSTR_READY handshake.

Parameters:
- INSTR_W, 32, instruction width; opcode is always the top OPCODE_W bits.
- OPCODE_W, 8, opcode field width.
- ALUOP_W, 4, ALUOP output width; must be 4 or more when EN_EXT=1, and 3 or more otherwise.
- EN_EXT, 1, enables opcodes 0x0C-0x11; when 0, those opcodes are illegal.

Ports:
- CLK  in  1  clock; rising-edge active.
- RESET_N  in  1  reset; asynchronous, active-low.
- INSTRUCTION  in  INSTR_W  instruction word from instruction memory.
- INSTR_VALID  in  1  INSTRUCTION is valid.
- INSTR_READY  out  1  unit accepts an instruction this cycle.
- BUSYWAIT  in  1  data memory/cache busy.
- ALUOP  out  ALUOP_W  ALU operation select.
- WRITEENABLE  out  1  register-file write.
- TWOSCOMPMUX_SEL  out  1  selects negated operand.
- IMMEDMUX_SEL  out  1  selects immediate operand.
- BRANCHENABLE  out  1  beq.
- BNEENABLE  out  1  bne.
- JUMPENABLE  out  1  jump.
- WRITEMUX_SEL  out  1  write-back source is memory read data.
- READ  out  1  data-memory read strobe.
- WRITE  out  1  data-memory write strobe.
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (RESET_N=0, asynchronous): all outputs 0, FSM to IDLE. Any memory access in flight is abandoned and READ/WRITE drop immediately.
- All control outputs are registered. INSTR_READY is combinational from state and BUSYWAIT.
- Accept condition: INSTR_VALID && INSTR_READY at a rising edge. On accept, the decode is loaded into the output registers, so decode latency is 1 cycle.
- FSM states: IDLE, EXEC, MEM_WAIT, WB.
- IDLE:
  - INSTR_READY=1; all outputs 0.
  - On accept, go to EXEC.
- EXEC (lasts one cycle):
  - Non-memory op: outputs reflect the decode. INSTR_READY=1. On accept, stay in EXEC with the new decode (back-to-back issue); otherwise go to IDLE.
  - Memory op: READ or WRITE is asserted. INSTR_READY=0. Go to MEM_WAIT.
- MEM_WAIT:
  - READ/WRITE and ALUOP are held while BUSYWAIT=1.
  - When BUSYWAIT=0, READ/WRITE deassert at the next edge.
  - Load: go to WB.
  - Store: INSTR_READY=1 in the BUSYWAIT=0 cycle. On accept go to EXEC, else go to IDLE.
- WB (lasts one cycle):
  - WRITEENABLE=1 and WRITEMUX_SEL=1.
  - INSTR_READY=1. On accept go to EXEC, else go to IDLE.
- Decode table (WRITEENABLE=1 unless stated; ALUOP zero-extended to ALUOP_W):
  - 0x00 loadi: ALUOP 000, IMMED.
  - 0x01 mov: ALUOP 000.
  - 0x02 add: ALUOP 001.
  - 0x03 sub: ALUOP 001, TWOSCOMP.
  - 0x04 and: ALUOP 010.
  - 0x05 or: ALUOP 011.
  - 0x06 jump: ALUOP 100, JUMP, WE=0.
  - 0x07 beq: ALUOP 001, TWOSCOMP, BRANCH, WE=0.
  - 0x08 lwd: ALUOP 101, READ, write-back in WB only.
  - 0x09 lwi: as lwd, plus IMMED.
  - 0x0A swd: ALUOP 110, WRITE, WE=0.
  - 0x0B swi: as swd, plus IMMED.
  - EN_EXT=1 only, register ops:
    - 0x0C mult: ALUOP 0111.
    - 0x0D sll: ALUOP 1000, IMMED.
    - 0x0E srl: ALUOP 1001, IMMED.
    - 0x0F sra: ALUOP 1010, IMMED.
    - 0x10 ror: ALUOP 1011, IMMED.
  - EN_EXT=1 only, 0x11 bne: ALUOP 001, TWOSCOMP, BNEENABLE, WE=0.
  - Loads keep WRITEENABLE=0 during EXEC and MEM_WAIT.
- Undefined opcode: treated as a non-memory op. In EXEC, ALUOP=0, all enables 0, ILLEGAL=1 for that one cycle. No register write and no PC effect.
- BUSYWAIT is ignored outside MEM_WAIT.
- If BUSYWAIT is already 0 on entry to MEM_WAIT, the access completes there, giving a 2-cycle memory op.
- Changes on INSTRUCTION without an accept do not alter the outputs.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams OP_LOADI..OP_BNE;
  - ALUOP localparams ALU_FWD, ALU_ADD, ALU_AND, ALU_OR, ALU_JMP, ALU_LD, ALU_ST, ALU_MUL, ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROR;
  - state encodings.
- Sub-module ctrl_decoder: purely combinational opcode-to-control-bundle mapping with EN_EXT gating, plus is_mem, is_load and illegal flags.
- The top level holds the FSM and output registers.

Test Plan:
- Reset check: assert RESET_N=0 mid-MEM_WAIT of lwd with BUSYWAIT=1 -> READ=0 immediately, all outputs 0, INSTR_READY=1 after release.
- Back-to-back arithmetic: add(0x02) then sub(0x03), INSTR_VALID held high -> EXEC on 2 consecutive cycles; ALUOP=0001 with WE=1, then ALUOP=0001 with TWOSCOMP=1; INSTR_READY constant 1.
- Load with stall: lwi(0x09), BUSYWAIT high 3 cycles -> READ=1 and IMMED=1 for 4 cycles with WE=0; then 1 WB cycle with WE=1 and WRITEMUX_SEL=1; INSTR_READY low 4 cycles.
- Store with zero wait: swd(0x0A), BUSYWAIT=0 -> WRITE=1 for 2 cycles, WE=0 throughout, next instruction accepted in the MEM_WAIT cycle.
- Extended ops and gating: with EN_EXT=1, sra(0x0F) -> ALUOP=1010, IMMED=1; bne(0x11) -> BNEENABLE=1, WE=0. With EN_EXT=0, 0x0F -> ILLEGAL pulse, ALUOP=0, WE=0.
- Undefined opcode: issue 0xFF -> single-cycle ILLEGAL, no enables asserted, unit returns to IDLE.
